// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through and runs
// request/ready load/store transactions with lane steering, extension and timeout.
module mem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic        stall_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic        d_req_o,
  output logic        d_we_o,
  output logic [31:0] d_addr_o,
  output logic [3:0]  d_be_o,
  output logic [31:0] d_wdata_o,
  input  logic        d_ready_i,
  input  logic [31:0] d_rdata_i
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                d_req_q, d_req_d;
  logic                d_we_q, d_we_d;
  logic [DATA_W-1:0]   d_addr_q, d_addr_d;
  logic [3:0]          d_be_q, d_be_d;
  logic [DATA_W-1:0]   d_wdata_q, d_wdata_d;

  logic                is_load, is_store, is_mem;
  logic                size_b, size_h, sext;
  logic                misal;
  logic [3:0]          be;
  logic [DATA_W-1:0]   bus_wdata;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_data;

  // Operation decode; unknown encodings behave as NONE
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_b   = 1'b0;
    size_h   = 1'b0;
    sext     = 1'b0;
    case (mem_op_i)
      4'd1: begin is_load = 1'b1;  size_b = 1'b1; sext = 1'b1; end
      4'd2: begin is_load = 1'b1;  size_b = 1'b1; end
      4'd3: begin is_load = 1'b1;  size_h = 1'b1; sext = 1'b1; end
      4'd4: begin is_load = 1'b1;  size_h = 1'b1; end
      4'd5: begin is_load = 1'b1; end
      4'd6: begin is_store = 1'b1; size_b = 1'b1; end
      4'd7: begin is_store = 1'b1; size_h = 1'b1; end
      4'd8: begin is_store = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;
  assign misal  = (size_h & mem_addr_i[0]) |
                  (is_mem & ~size_b & ~size_h & (|mem_addr_i[1:0]));

  // Byte enables and lane-replicated store data
  always_comb begin
    if (size_b) begin
      be        = 4'b0001 << mem_addr_i[1:0];
      bus_wdata = {4{mem_sdata_i[7:0]}};
    end else if (size_h) begin
      be        = 4'b0011 << mem_addr_i[1:0];
      bus_wdata = {2{mem_sdata_i[15:0]}};
    end else begin
      be        = 4'b1111;
      bus_wdata = mem_sdata_i;
    end
  end

  // Lane extraction and sign/zero extension of the captured read word
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
    if (size_b) begin
      ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
    end else if (size_h) begin
      ld_data = {{16{sext & ld_half[15]}}, ld_half};
    end else begin
      ld_data = rdata_q;
    end
  end

  // Next-state and stage outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    d_req_d    = d_req_q;
    d_we_d     = d_we_q;
    d_addr_d   = d_addr_q;
    d_be_d     = d_be_q;
    d_wdata_d  = d_wdata_q;
    wdata_o    = wdata_i;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    stall_o    = 1'b0;
    addr_err_o = 1'b0;
    bus_err_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          wreg_o = 1'b0;
          if (misal) begin
            addr_err_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            d_req_d   = 1'b1;
            d_we_d    = is_store;
            d_addr_d  = {mem_addr_i[31:2], 2'b00};
            d_be_d    = be;
            d_wdata_d = bus_wdata;
            cnt_d     = '0;
            err_d     = 1'b0;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        wreg_o  = 1'b0;
        if (d_ready_i) begin
          rdata_d = d_rdata_i;
          d_req_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          d_req_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        if (err_q) begin
          wdata_o   = '0;
          wreg_o    = 1'b0;
          bus_err_o = 1'b1;
        end else if (is_load) begin
          wdata_o = ld_data;
        end else begin
          wreg_o = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_be_q    <= '0;
      d_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      d_req_q   <= d_req_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_be_q    <= d_be_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  assign d_req_o   = d_req_q;
  assign d_we_o    = d_we_q;
  assign d_addr_o  = d_addr_q;
  assign d_be_o    = d_be_q;
  assign d_wdata_o = d_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset-in-flight sequence and
// randomized traffic against an arithmetic reference model.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        resetn;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_sdata_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_o, addr_err_o, bus_err_o;
  logic        d_req_o, d_we_o;
  logic [31:0] d_addr_o;
  logic [3:0]  d_be_o;
  logic [31:0] d_wdata_o;
  logic        d_ready_i;
  logic [31:0] d_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .stall_o(stall_o),
    .addr_err_o(addr_err_o), .bus_err_o(bus_err_o),
    .d_req_o(d_req_o), .d_we_o(d_we_o), .d_addr_o(d_addr_o), .d_be_o(d_be_o),
    .d_wdata_o(d_wdata_o), .d_ready_i(d_ready_i), .d_rdata_i(d_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = pass-through, 1 = misaligned, 2 = bus access
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wd;
    logic        wreg;
    int          waits;
    int          kind;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] bus_wdata;
    logic [31:0] res;
    logic        exp_wreg;
    logic        bus_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the architectural rules, using plain arithmetic
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [4:0] wd,
                                 input logic wreg, input int waits);
    vec_t v;
    int size, off;
    bit load, sgn;
    logic [31:0] mask, val;
    v = '{default: 0};
    v.op = op; v.addr = addr; v.sdata = sdata; v.alu = alu; v.rdata = rdata;
    v.wd = wd; v.wreg = wreg; v.waits = waits;
    size = 0; load = 0; sgn = 0;
    case (op)
      4'd1: begin size = 1; load = 1; sgn = 1; end
      4'd2: begin size = 1; load = 1; end
      4'd3: begin size = 2; load = 1; sgn = 1; end
      4'd4: begin size = 2; load = 1; end
      4'd5: begin size = 4; load = 1; end
      4'd6: size = 1;
      4'd7: size = 2;
      4'd8: size = 4;
      default: size = 0;
    endcase
    off = int'(addr % 4);
    if (size == 0) begin
      v.kind = 0; v.res = alu; v.exp_wreg = wreg;
    end else if ((off % size) != 0) begin
      v.kind = 1; v.exp_wreg = 1'b0;
    end else begin
      v.kind  = 2;
      v.daddr = addr - 32'(off);
      v.be    = 4'(((1 << size) - 1) << off);
      v.we    = !load;
      v.bus_wdata = (size == 1) ? sdata[7:0] * 32'h0101_0101 :
                    (size == 2) ? sdata[15:0] * 32'h0001_0001 : sdata;
      v.bus_err = (waits >= int'(TO));
      if (v.bus_err) begin
        v.res = 0; v.exp_wreg = 1'b0;
      end else if (load) begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
        val  = (rdata >> (8 * off)) & mask;
        if (sgn && val[8 * size - 1]) val = val | ~mask;
        v.res = val; v.exp_wreg = wreg;
      end else begin
        v.exp_wreg = 1'b0;
      end
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    bit done;
    int exp_n;
    @(negedge clk);
    mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata;
    wdata_i = v.alu; wd_i = v.wd; wreg_i = v.wreg;
    d_ready_i = 1'($urandom_range(0, 1));
    d_rdata_i = $urandom;
    #1;
    case (v.kind)
      0: begin
        chk("pass_wdata", wdata_o, v.res);
        chk("pass_wd", 32'(wd_o), 32'(v.wd));
        chk("pass_wreg", 32'(wreg_o), 32'(v.exp_wreg));
        chk("pass_stall", 32'(stall_o), 0);
        chk("pass_addr_err", 32'(addr_err_o), 0);
        @(negedge clk); #1;
        chk("pass_no_req", 32'(d_req_o), 0);
      end
      1: begin
        chk("mis_addr_err", 32'(addr_err_o), 1);
        chk("mis_wreg", 32'(wreg_o), 0);
        chk("mis_stall", 32'(stall_o), 0);
        mem_op_i = 4'd0;
        @(negedge clk); #1;
        chk("mis_no_req", 32'(d_req_o), 0);
        chk("mis_pulse_end", 32'(addr_err_o), 0);
      end
      default: begin
        chk("idle_stall", 32'(stall_o), 1);
        chk("idle_wreg", 32'(wreg_o), 0);
        chk("idle_addr_err", 32'(addr_err_o), 0);
        n = 0; done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
          @(negedge clk); #1;
          if (!stall_o) begin
            done = 1;
          end else begin
            n++;
            chk("req_active", 32'(d_req_o), 1);
            if (n == 1) begin
              chk("req_addr", d_addr_o, v.daddr);
              chk("req_be", 32'(d_be_o), 32'(v.be));
              chk("req_we", 32'(d_we_o), 32'(v.we));
              if (v.we) chk("req_wdata", d_wdata_o, v.bus_wdata);
            end
            d_ready_i = ((n - 1) == v.waits);
            d_rdata_i = d_ready_i ? v.rdata : $urandom;
          end
        end
        if (!done) begin
          checks++; errors++;
          $display("FAIL done_wait: stage still stalled after 64 cycles, expected DONE");
          resetn = 1'b0; #1; resetn = 1'b1;
        end else begin
          exp_n = v.bus_err ? int'(TO) : v.waits + 1;
          chk("req_cycles", 32'(n), 32'(exp_n));
          chk("done_wreg", 32'(wreg_o), 32'(v.exp_wreg));
          chk("done_bus_err", 32'(bus_err_o), 32'(v.bus_err));
          chk("done_wd", 32'(wd_o), 32'(v.wd));
          chk("done_req_low", 32'(d_req_o), 0);
          if (!v.we || v.bus_err) chk("done_wdata", wdata_o, v.res);
        end
        d_ready_i = 1'($urandom_range(0, 1));
        mem_op_i = 4'd0;
      end
    endcase
    d_ready_i = 1'b0;
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0;
    mem_op_i = 4'd0; mem_addr_i = 0; mem_sdata_i = 0;
    wdata_i = 32'h1357_9BDF; wd_i = 5'd4; wreg_i = 1'b1;
    d_ready_i = 1'b0; d_rdata_i = 0;

    tbl[0]  = '{op:4'd0, alu:32'h7, wd:5'd3, wreg:1'b1, kind:0, res:32'h7, exp_wreg:1'b1, default:0};
    tbl[1]  = '{op:4'd1, addr:32'h103, rdata:32'h80AA_BBCC, wd:5'd5, wreg:1'b1, waits:0, kind:2,
                daddr:32'h100, be:4'b1000, we:1'b0, res:32'hFFFF_FF80, exp_wreg:1'b1, default:0};
    tbl[2]  = '{op:4'd2, addr:32'h103, rdata:32'h80AA_BBCC, wd:5'd5, wreg:1'b1, waits:0, kind:2,
                daddr:32'h100, be:4'b1000, we:1'b0, res:32'h0000_0080, exp_wreg:1'b1, default:0};
    tbl[3]  = '{op:4'd7, addr:32'h22, sdata:32'h1234_ABCD, wd:5'd6, wreg:1'b1, waits:1, kind:2,
                daddr:32'h20, be:4'b1100, we:1'b1, bus_wdata:32'hABCD_ABCD, exp_wreg:1'b0, default:0};
    tbl[4]  = '{op:4'd5, addr:32'h41, wd:5'd7, wreg:1'b1, kind:1, default:0};
    tbl[5]  = '{op:4'd5, addr:32'h40, rdata:32'h1111_2222, wd:5'd8, wreg:1'b1, waits:10, kind:2,
                daddr:32'h40, be:4'b1111, we:1'b0, res:32'h0, exp_wreg:1'b0, bus_err:1'b1, default:0};
    tbl[6]  = '{op:4'd3, addr:32'h102, rdata:32'h80AA_BBCC, wd:5'd9, wreg:1'b1, waits:2, kind:2,
                daddr:32'h100, be:4'b1100, we:1'b0, res:32'hFFFF_80AA, exp_wreg:1'b1, default:0};
    tbl[7]  = '{op:4'd4, addr:32'h100, rdata:32'h80AA_BBCC, wd:5'd10, wreg:1'b1, waits:0, kind:2,
                daddr:32'h100, be:4'b0011, we:1'b0, res:32'h0000_BBCC, exp_wreg:1'b1, default:0};
    tbl[8]  = '{op:4'd6, addr:32'h1, sdata:32'h0000_005A, wd:5'd11, wreg:1'b1, waits:0, kind:2,
                daddr:32'h0, be:4'b0010, we:1'b1, bus_wdata:32'h5A5A_5A5A, exp_wreg:1'b0, default:0};
    tbl[9]  = '{op:4'd8, addr:32'h40, sdata:32'hDEAD_BEEF, wd:5'd12, wreg:1'b1, waits:0, kind:2,
                daddr:32'h40, be:4'b1111, we:1'b1, bus_wdata:32'hDEAD_BEEF, exp_wreg:1'b0, default:0};
    tbl[10] = '{op:4'd5, addr:32'h44, rdata:32'h1234_5678, wd:5'd13, wreg:1'b1, waits:3, kind:2,
                daddr:32'h44, be:4'b1111, we:1'b0, res:32'h1234_5678, exp_wreg:1'b1, default:0};
    tbl[11] = '{op:4'd3, addr:32'h101, wd:5'd14, wreg:1'b1, kind:1, default:0};
    tbl[12] = '{op:4'd12, alu:32'hCAFE_F00D, wd:5'd9, wreg:1'b0, kind:0, res:32'hCAFE_F00D,
                exp_wreg:1'b0, default:0};
    tbl[13] = '{op:4'd1, addr:32'h2, rdata:32'h0011_7F00, wd:5'd15, wreg:1'b1, waits:1, kind:2,
                daddr:32'h0, be:4'b0100, we:1'b0, res:32'h0000_0011, exp_wreg:1'b1, default:0};

    #12;
    chk("rst_req", 32'(d_req_o), 0);
    chk("rst_we", 32'(d_we_o), 0);
    chk("rst_addr", d_addr_o, 0);
    chk("rst_be", 32'(d_be_o), 0);
    chk("rst_wdata", d_wdata_o, 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_pass", wdata_o, 32'h1357_9BDF);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // Reset asserted during the second REQ cycle of a word load
    @(negedge clk);
    mem_op_i = 4'd5; mem_addr_i = 32'h80; wd_i = 5'd2; wreg_i = 1'b1; d_ready_i = 1'b0;
    #1; chk("rr_stall", 32'(stall_o), 1);
    @(negedge clk); #1; chk("rr_req1", 32'(d_req_o), 1);
    @(negedge clk); #1; chk("rr_req2", 32'(d_req_o), 1);
    resetn = 1'b0;
    #1;
    chk("rr_req_drop", 32'(d_req_o), 0);
    chk("rr_addr_clr", d_addr_o, 0);
    mem_op_i = 4'd0; wdata_i = 32'h0000_0055;
    #1; chk("rr_idle_stall", 32'(stall_o), 0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); #1;
    chk("rr_pass_wdata", wdata_o, 32'h0000_0055);
    chk("rr_pass_wreg", 32'(wreg_o), 1);
    chk("rr_pass_req", 32'(d_req_o), 0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      v = model(op, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline, placed between the EX/MEM and MEM/WB pipeline registers in place of the current pass-through memory stage. Non-memory instructions pass through combinationally with zero added latency. Loads and stores run a request/ready transaction on a single-port data bus, with byte enables, sign or zero extension and misalignment detection. While a transaction is outstanding, the stage stalls the upstream pipeline.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of REQ-state cycles without `d_ready_i` before the access is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_op_i  in  4  0=NONE, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; values 9–15 are treated as NONE.
- mem_addr_i  in  32  effective address from EX.
- mem_sdata_i  in  32  store data (rt value).
- wdata_i  in  32  ALU result from EX/MEM.
- wd_i  in  5  destination register.
- wreg_i  in  1  register write enable.
- wdata_o  out  32  writeback data to MEM/WB.
- wd_o  out  5  destination register to MEM/WB.
- wreg_o  out  1  write enable to MEM/WB.
- stall_o  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers and insert a bubble into MEM/WB.
- addr_err_o  out  1  one-cycle pulse on a misaligned access.
- bus_err_o  out  1  one-cycle pulse on a timeout.
- d_req_o  out  1  bus request (registered).
- d_we_o  out  1  1 = write (registered).
- d_addr_o  out  32  word-aligned address, `{addr[31:2],2'b00}` (registered).
- d_be_o  out  4  byte enables; bit n selects byte lane n (registered).
- d_wdata_o  out  32  lane-replicated store data (registered).
- d_ready_i  in  1  completes the request in the cycle it is sampled high.
- d_rdata_i  in  32  read word, valid when `d_ready_i` is high.

## Operation
State machine: IDLE, REQ, DONE.

IDLE
- mem_op NONE (including 9–15): `wdata_o = wdata_i`, `wd_o = wd_i`, `wreg_o = wreg_i`, `stall_o = 0`. Output is combinational.
- Misaligned access (halfword with `addr[0] = 1`, or word with `addr[1:0] != 0`):
  - no bus request is issued;
  - `addr_err_o = 1` and `wreg_o = 0` in the same cycle;
  - `stall_o = 0`, state stays IDLE.
- Aligned memory op:
  - `stall_o = 1`, `wreg_o = 0`;
  - on the clock edge: load the `d_*` registers, `d_req_o <= 1`, clear the counter, move to REQ.

REQ
- `stall_o = 1`; the `d_*` outputs hold their values.
- `d_ready_i` high:
  - capture `d_rdata_i` into the data register;
  - `d_req_o <= 0`, move to DONE.
- `d_ready_i` low with counter == TIMEOUT-1:
  - `d_req_o <= 0`, set the error flag, move to DONE.
- Otherwise: counter increments.

DONE
- `stall_o = 0`.
- Load: `wdata_o` = extended captured data, `wd_o = wd_i`, `wreg_o = wreg_i`.
- Store: `wreg_o = 0`.
- Timeout: `wdata_o = 0`, `wreg_o = 0`, `bus_err_o = 1`.
- Always returns to IDLE; the upstream pipeline advances on this edge.

Lane rules (little-endian, `b = addr[1:0]`):
- SB / LB / LBU: `d_be_o = 1<<b`.
- SH / LH / LHU: `d_be_o = 4'b0011 << b`.
- SW / LW: `d_be_o = 4'b1111`.
- `d_wdata_o`: SB = `{4{sdata[7:0]}}`, SH = `{2{sdata[15:0]}}`, SW = sdata.
- Loads select the byte or halfword at lane b. LB and LH sign-extend; LBU and LHU zero-extend.
- Loads assert `d_we_o = 0` and `d_be_o` per lane; stores assert `d_we_o = 1`.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, counter = 0, error flag = 0;
  - `d_req_o`, `d_we_o`, `d_addr_o`, `d_be_o`, `d_wdata_o` and the captured data all = 0.
  - The combinational outputs then follow the IDLE rules.
- Reset during REQ drops `d_req_o` at once; the bus must tolerate an abandoned request.
- Non-memory op: 0 added cycles.
- Memory op with ready in the first REQ cycle: the instruction occupies the stage for 3 cycles, 2 of them stalled.
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ, ready sampled.
  - Cycle 2: DONE.
- Each wait cycle in REQ adds one cycle.
- Timeout: exactly TIMEOUT cycles in REQ, then DONE.
- `d_ready_i` while not in REQ is ignored.
- `d_ready_i` and the timeout in the same cycle: ready wins, no error.
- Back-to-back memory ops: DONE is always followed by IDLE, so consecutive ops each take at least 3 cycles.
- EX/MEM inputs are assumed stable while `stall_o = 1`. In DONE, the `wd_i` and `wreg_i` values of the same instruction are still present.

## Test plan
- ADD result 0x0000_0007 with `wreg_i = 1` and mem_op NONE -> `wdata_o = 7`, `wreg_o = 1`, `stall_o = 0` in the same cycle.
- LB at address 0x103 with `d_rdata_i = 0x80AA_BBCC` and ready on the first REQ cycle -> `d_be_o = 4'b1000`, `d_addr_o = 0x100`; 2 stall cycles; DONE gives `wdata_o = 0xFFFF_FF80`. LBU on the same data gives `0x0000_0080`.
- SH of sdata 0x1234_ABCD at address 0x22 -> `d_we_o = 1`, `d_be_o = 4'b1100`, `d_wdata_o = 0xABCD_ABCD`, `wreg_o = 0` in DONE.
- LW at address 0x41 -> `addr_err_o` pulses for one cycle, `d_req_o` stays 0, `stall_o = 0`, `wreg_o = 0`.
- LW with `d_ready_i` held low and TIMEOUT = 4 -> exactly 4 REQ cycles, then DONE with `bus_err_o = 1`, `wreg_o = 0`, `wdata_o = 0`.
- `resetn` pulled low in the second REQ cycle of an LW -> `d_req_o` is 0 without waiting for a clock edge; after release, state is IDLE and a NONE op passes through.
